// File: rtl/mux_select_scanner_if.sv
// Signal bundle between the scan sequencer (master) and the mux and frame consumer (slave).
interface mux_select_scanner_if;
    logic       EN;
    logic [3:0] MASK;
    logic       MUX_OUT;
    logic       SEL0;
    logic       SEL1;
    logic [3:0] FRAME;
    logic       FRAME_VALID;
    logic       FRAME_READY;
    logic       OVERRUN;

    modport master (
        input  EN, MASK, MUX_OUT, FRAME_READY,
        output SEL0, SEL1, FRAME, FRAME_VALID, OVERRUN
    );

    modport slave (
        output EN, MASK, MUX_OUT, FRAME_READY,
        input  SEL0, SEL1, FRAME, FRAME_VALID, OVERRUN
    );
endinterface

// File: rtl/mux_select_scanner.sv
// Scan sequencer for a 4-to-1 mux: steps SEL through the latched channels, samples
// MUX_OUT on the last dwell cycle of each, and emits one frame per scan over valid/ready.
module mux_select_scanner #(
    parameter int DWELL = 4,
    parameter int CNT_W = 8
) (
    input logic                  CLK,
    input logic                  RESET,
    mux_select_scanner_if.master bus
);
    typedef enum logic {IDLE, SCAN} state_t;

    state_t           state, state_next;
    logic [CNT_W-1:0] cnt;
    logic [1:0]       sel;
    logic [3:0]       mask_l;
    logic [3:0]       shadow;
    logic [3:0]       frame;
    logic [3:0]       frame_new;
    logic             frame_valid;
    logic             overrun;
    logic             dwell_done;
    logic             last_ch;
    logic             mask_nz;
    logic             start;
    logic             step;
    logic             complete;

    function automatic logic [1:0] lowest_ch(input logic [3:0] m);
        lowest_ch = 2'd0;
        for (int i = 3; i >= 0; i--)
            if (m[i]) lowest_ch = 2'(i);
    endfunction

    function automatic logic [1:0] highest_ch(input logic [3:0] m);
        highest_ch = 2'd0;
        for (int i = 0; i < 4; i++)
            if (m[i]) highest_ch = 2'(i);
    endfunction

    // Nearest enabled channel strictly above ch; only called when one exists.
    function automatic logic [1:0] next_ch(input logic [3:0] m, input logic [1:0] ch);
        next_ch = ch;
        for (int i = 3; i >= 0; i--)
            if (m[i] && i > int'(ch)) next_ch = 2'(i);
    endfunction

    assign dwell_done = (cnt == CNT_W'(DWELL - 1));
    assign last_ch    = (sel == highest_ch(mask_l));
    assign mask_nz    = |bus.MASK;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge CLK) begin
        if (RESET) state <= IDLE;
        else       state <= state_next;
    end

    // NOTE: every combinational output gets a default first so no path infers a latch.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (bus.EN && mask_nz) state_next = SCAN;
            SCAN:    if (!bus.EN || (dwell_done && last_ch && !mask_nz)) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        start    = 1'b0;
        step     = 1'b0;
        complete = 1'b0;
        case (state)
            IDLE: start = bus.EN && mask_nz;
            SCAN: begin
                complete = dwell_done && last_ch;
                step     = bus.EN;
                start    = bus.EN && mask_nz && complete;
            end
            default: ;
        endcase
    end

    // Frame as it will look once this edge's sample is merged in.
    always_comb begin
        frame_new      = shadow;
        frame_new[sel] = bus.MUX_OUT;
        frame_new      = frame_new & mask_l;
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            cnt         <= '0;
            sel         <= 2'd0;
            mask_l      <= 4'd0;
            shadow      <= 4'd0;
            frame       <= 4'd0;
            frame_valid <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            // A completion beats a consume; an unconsumed frame makes the new one drop.
            if (complete && frame_valid && !bus.FRAME_READY) begin
                overrun <= 1'b1;
            end else if (complete) begin
                frame       <= frame_new;
                frame_valid <= 1'b1;
            end else if (frame_valid && bus.FRAME_READY) begin
                frame_valid <= 1'b0;
            end

            if (start) begin
                mask_l <= bus.MASK;
                sel    <= lowest_ch(bus.MASK);
                cnt    <= '0;
                shadow <= 4'd0;
            end else if (step) begin
                if (dwell_done) begin
                    shadow[sel] <= bus.MUX_OUT;
                    cnt         <= '0;
                    if (!last_ch) sel <= next_ch(mask_l, sel);
                end else begin
                    cnt <= cnt + CNT_W'(1);
                end
            end else if (state == SCAN) begin
                cnt <= '0;
            end
        end
    end

    assign bus.SEL0        = sel[0];
    assign bus.SEL1        = sel[1];
    assign bus.FRAME       = frame;
    assign bus.FRAME_VALID = frame_valid;
    assign bus.OVERRUN     = overrun;
endmodule

// File: tb/tb_mux_select_scanner.sv
// Self-checking bench: schedule-based reference model of the scanner plus directed literal checks.
module tb_mux_select_scanner;
    localparam int DWELL = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic [3:0] mask;
    logic       rdy;
    logic [3:0] mux_in;

    int n_vec = 0;
    int n_err = 0;

    mux_select_scanner_if bus ();

    assign bus.EN          = en;
    assign bus.MASK        = mask;
    assign bus.FRAME_READY = rdy;
    // The driven MUX_4to1: OUT follows the selected input.
    assign bus.MUX_OUT     = mux_in[{bus.SEL1, bus.SEL0}];

    mux_select_scanner #(.DWELL(DWELL), .CNT_W(8)) dut (
        .CLK   (clk),
        .RESET (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Reference model: a scan is a list of channels; time since scan start picks channel and sample slot.
    bit         m_active;
    int         m_chans[$];
    int         m_t;
    logic [3:0] m_samples;
    logic [3:0] m_mask;
    logic [3:0] m_frame;
    int         m_sel;
    bit         m_valid;
    bit         m_ovr;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    function automatic logic [1:0] sel_now();
        return {bus.SEL1, bus.SEL0};
    endfunction

    task automatic model_start();
        m_mask = mask;
        m_chans.delete();
        for (int i = 0; i < 4; i++)
            if (mask[i]) m_chans.push_back(i);
        m_t       = 0;
        m_samples = 4'd0;
        m_sel     = m_chans[0];
        m_active  = 1'b1;
    endtask

    task automatic model_step();
        bit         complete;
        logic [3:0] built;
        complete = 1'b0;
        if (rst) begin
            m_active = 1'b0; m_t = 0; m_samples = 4'd0; m_mask = 4'd0;
            m_frame = 4'd0; m_sel = 0; m_valid = 1'b0; m_ovr = 1'b0;
            m_chans.delete();
            return;
        end
        if (m_active && (m_t % DWELL) == DWELL - 1) begin
            int ch;
            ch = m_chans[m_t / DWELL];
            m_samples[ch] = mux_in[ch];
            complete = ((m_t / DWELL) == m_chans.size() - 1);
        end
        if (complete) begin
            if (m_valid && !rdy) begin
                m_ovr = 1'b1;
            end else begin
                for (int i = 0; i < 4; i++) built[i] = m_mask[i] & m_samples[i];
                m_frame = built;
                m_valid = 1'b1;
            end
        end else if (m_valid && rdy) begin
            m_valid = 1'b0;
        end
        if (!m_active) begin
            if (en && mask != 4'd0) model_start();
        end else if (!en) begin
            m_active = 1'b0;
        end else if (complete) begin
            if (mask != 4'd0) model_start();
            else m_active = 1'b0;
        end else begin
            m_t++;
            m_sel = m_chans[m_t / DWELL];
        end
    endtask

    // One clock: advance the model with the current inputs, then compare every output after the edge.
    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        check("sel", sel_now(), m_sel);
        check("frame", bus.FRAME, m_frame);
        check("frame_valid", bus.FRAME_VALID, m_valid);
        check("overrun", bus.OVERRUN, m_ovr);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; mask = 4'd0; rdy = 1'b0; mux_in = 4'd0;
        #2;
        do_reset();
        check("rst_sel", sel_now(), 2'b00);
        check("rst_frame", bus.FRAME, 4'b0000);
        check("rst_valid", bus.FRAME_VALID, 1'b0);
        check("rst_overrun", bus.OVERRUN, 1'b0);

        // Full mask: 16-cycle frames of 0101.
        mux_in = 4'b0101; mask = 4'b1111; rdy = 1'b1; en = 1'b1;
        tick();
        check("t1_exit_sel", sel_now(), 2'b00);
        for (int k = 1; k <= 32; k++) begin
            tick();
            check("t1_sel", sel_now(), 32'((k % 16) / 4));
            if (k == 16 || k == 32) begin
                check("t1_frame", bus.FRAME, 4'b0101);
                check("t1_valid", bus.FRAME_VALID, 1'b1);
            end else if (k == 15) begin
                check("t1_valid_early", bus.FRAME_VALID, 1'b0);
            end
        end

        // Sparse mask, then a mid-frame mask change that only applies to the next scan.
        do_reset();
        mux_in = 4'b0101; mask = 4'b1010; rdy = 1'b1; en = 1'b1;
        tick();
        check("t2_exit_sel", sel_now(), 2'b01);
        for (int k = 1; k <= 16; k++) begin
            if (k == 3) mask = 4'b0100;
            tick();
            if (k < 4) check("t2_sel_ch1", sel_now(), 2'b01);
            if (k == 4) check("t2_sel_ch3", sel_now(), 2'b11);
            if (k == 8) begin
                check("t2_frame_a", bus.FRAME, 4'b0000);
                check("t2_valid_a", bus.FRAME_VALID, 1'b1);
                check("t2_sel_ch2", sel_now(), 2'b10);
            end
            if (k == 12 || k == 16) begin
                check("t2_frame_b", bus.FRAME, 4'b0100);
                check("t2_valid_b", bus.FRAME_VALID, 1'b1);
            end
        end

        // Consumer stalled: overrun, then a consume coinciding with a completion.
        do_reset();
        mux_in = 4'b0101; mask = 4'b1111; rdy = 1'b0; en = 1'b1;
        tick();
        for (int k = 1; k <= 50; k++) begin
            if (k == 33) mux_in = 4'b1010;
            rdy = (k == 48);
            tick();
            if (k == 16) begin
                check("t3_frame1", bus.FRAME, 4'b0101);
                check("t3_valid1", bus.FRAME_VALID, 1'b1);
            end
            if (k == 31) check("t3_no_overrun_yet", bus.OVERRUN, 1'b0);
            if (k == 32 || k == 47) begin
                check("t3_overrun", bus.OVERRUN, 1'b1);
                check("t3_frame_held", bus.FRAME, 4'b0101);
            end
            if (k == 48 || k == 50) begin
                check("t3_frame_reload", bus.FRAME, 4'b1010);
                check("t3_valid_kept", bus.FRAME_VALID, 1'b1);
            end
        end

        // Reset mid-scan with a pending frame and overrun, then an all-zero mask.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t5_sel", sel_now(), 2'b00);
        check("t5_frame", bus.FRAME, 4'b0000);
        check("t5_valid", bus.FRAME_VALID, 1'b0);
        check("t5_overrun", bus.OVERRUN, 1'b0);
        mask = 4'b0000; en = 1'b1;
        for (int k = 0; k < 20; k++) begin
            tick();
            check("t5_idle_sel", sel_now(), 2'b00);
        end

        // Enable dropped partway through channel 1.
        do_reset();
        mux_in = 4'b0101; mask = 4'b1111; rdy = 1'b1; en = 1'b1;
        tick();
        for (int k = 1; k <= 5; k++) tick();
        en = 1'b0;
        for (int k = 6; k <= 11; k++) begin
            tick();
            check("t4_sel_hold", sel_now(), 2'b01);
            check("t4_no_valid", bus.FRAME_VALID, 1'b0);
        end
        en = 1'b1;
        tick();
        check("t4_restart_sel", sel_now(), 2'b00);
        for (int k = 1; k <= 16; k++) tick();
        check("t4_frame", bus.FRAME, 4'b0101);
        check("t4_valid", bus.FRAME_VALID, 1'b1);

        // Random traffic against the model.
        do_reset();
        en = 1'b1; mask = 4'b1111;
        for (int c = 0; c < 4000; c++) begin
            rst = ($urandom_range(0, 399) == 0);
            if ($urandom_range(0, 29) == 0) en = ~en;
            if ($urandom_range(0, 19) == 0) mask = 4'($urandom_range(0, 15));
            if (c < 2000) rdy = 1'($urandom_range(0, 1));
            else          rdy = ($urandom_range(0, 7) == 0);
            mux_in = 4'($urandom_range(0, 15));
            tick();
        end
        rst = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/mux_select_scanner.md
Name: mux_select_scanner

Overview:
Upstream sequencer for the 4-to-1 multiplexer (MUX_4to1). It drives SEL1/SEL0 to step through the enabled input channels. It holds each selection for a programmable dwell time, then samples the mux OUT. Once per scan it assembles the samples into a 4-bit frame and hands it downstream over a valid/ready handshake.

Parameters:
DWELL, 4, cycles each channel stays selected (legal range 2..255); MUX_OUT is sampled on the last dwell cycle
CNT_W, 8, width of the internal dwell counter; must hold DWELL-1

Ports:
CLK  input  1  single clock; all state updates on rising edge
RESET  input  1  synchronous, active-high reset
EN  input  1  scan enable
MASK  input  4  channel enable; bit i = mux input Ii
MUX_OUT  input  1  OUT of the driven MUX_4to1
SEL0  output  1  mux select LSB
SEL1  output  1  mux select MSB
FRAME  output  4  last completed frame; bit i = sample of channel i, 0 for masked channels
FRAME_VALID  output  1  FRAME holds an unconsumed frame
FRAME_READY  input  1  downstream accepts FRAME
OVERRUN  output  1  sticky; a completed frame was dropped

Behaviour:
- Clock and reset: one clock, CLK; reset is synchronous and active-high (RESET), sampled on the CLK rising edge.
- Reset values: SEL1/SEL0=00, FRAME=0000, FRAME_VALID=0, OVERRUN=0, state=IDLE, counter=0, shadow=0000, mask latch=0000.
- States: IDLE, SCAN.
- IDLE:
  - If EN=1 and MASK!=0, go to SCAN on the next edge.
  - On that edge: latch MASK, set SEL to the lowest enabled channel, counter=0, clear shadow.
  - If MASK=0, stay in IDLE; SEL holds.
- SCAN, each edge:
  - If counter<DWELL-1: counter+1, SEL held.
  - If counter=DWELL-1: shadow[ch] <= MUX_OUT, counter=0. If ch is not the highest latched channel, SEL advances to the next higher latched channel.
- Frame completion: the sample edge of the highest latched channel.
  - If FRAME_VALID=1 and FRAME_READY=0: frame dropped, FRAME unchanged, OVERRUN<=1.
  - Otherwise: FRAME <= shadow with the new bit merged and masked bits zeroed; FRAME_VALID<=1.
  - If EN=1, re-latch MASK and restart on the same edge at its lowest enabled channel (no IDLE bubble).
  - If EN=1 but the new MASK=0, go to IDLE.
- Frame period: N*DWELL cycles, N = number of latched channels. First FRAME_VALID rises N*DWELL edges after the IDLE-exit edge.
- Handshake:
  - FRAME_VALID clears on an edge where FRAME_VALID=1 and FRAME_READY=1, unless a frame completes on the same edge. In that case the new frame loads, FRAME_VALID stays 1, and OVERRUN is not set.
  - FRAME is stable while FRAME_VALID=1.
- EN=0 in SCAN: go to IDLE next edge. The partial frame is discarded. SEL, FRAME, FRAME_VALID and OVERRUN hold; the handshake still operates.
- MASK changes mid-scan are ignored until the next frame start.
- OVERRUN clears only on RESET.
- RESET mid-scan: all reset values on that edge; no frame emitted.
- SEL encoding: channel = {SEL1,SEL0}.

Test Plan:
- Mux I0=1, I1=0, I2=1, I3=0 driven by the scanner; DWELL=4; MASK=1111; EN=1; FRAME_READY=1 -> SEL sequence 00,01,10,11, 4 cycles each; FRAME_VALID rises at edge 16 after IDLE exit with FRAME=0101; repeats every 16 cycles.
- MASK=1010, same inputs -> SEL visits only 01 and 11; FRAME=0000 every 8 cycles. Set MASK=0100 mid-frame -> current frame unaffected; next frame FRAME=0100 every 4 cycles.
- FRAME_READY=0 throughout -> first frame 0101 held, OVERRUN=1 at edge 32, FRAME unchanged. Then FRAME_READY=1 for one cycle coincident with the next completion edge -> FRAME reloads, FRAME_VALID stays 1.
- EN dropped at cycle 6 of a scan -> IDLE next edge; SEL holds 01; no FRAME_VALID. Re-raise EN -> scan restarts at channel 0.
- RESET asserted mid-scan with FRAME_VALID=1 and OVERRUN=1 -> all outputs at reset values next edge. MASK=0000 with EN=1 -> stays IDLE; SEL=00 indefinitely.
